// File: rtl/ksa16_wb_frontend.sv
// Wishbone register front end that holds operands on the KSA16 adder for a settle window and captures its result.
// Optional done interrupt is enabled by defining KSA_FE_IRQ_EN.
module ksa16_wb_frontend #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] ksa_a,
    output logic [15:0] ksa_b,
    input  logic [15:0] ksa_sum,
    input  logic        ksa_cout,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [16:0] result_q, result_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_s;
    logic        acc_s, wr_s, rd_s, busy_s;
    logic [2:0]  off_s;
    logic        unused_s;
`ifdef KSA_FE_IRQ_EN
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
`endif

    assign unused_s = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

    assign acc_s  = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign wr_s   = acc_s & wbs_we_i;
    assign rd_s   = acc_s & ~wbs_we_i;
    assign off_s  = wbs_adr_i[4:2];
    assign busy_s = (state_q != ST_IDLE);

    // Read data mux; values reflect state before the acking edge.
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            3'd0: rdata_s = {16'd0, opa_q};
            3'd1: rdata_s = {16'd0, opb_q};
`ifdef KSA_FE_IRQ_EN
            3'd2: rdata_s = {29'd0, irq_en_q, 2'b00};
`else
            3'd2: rdata_s = 32'd0;
`endif
            3'd3: rdata_s = {29'd0, overrun_q, done_q, busy_s};
            3'd4: rdata_s = {15'd0, result_q};
            default: rdata_s = 32'd0;
        endcase
    end

    // Next-state logic for bus handshake, registers and sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        ack_d     = acc_s;
        dat_d     = rd_s ? rdata_s : 32'd0;
`ifdef KSA_FE_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_d     = done_q & irq_en_q;
`endif

        // Operand writes are blocked while busy so the adder inputs stay stable.
        if (wr_s && (off_s == 3'd0 || off_s == 3'd1)) begin
            if (busy_s) begin
                overrun_d = 1'b1;
            end else if (off_s == 3'd0) begin
                opa_d[7:0]  = wbs_sel_i[0] ? wbs_dat_i[7:0]  : opa_q[7:0];
                opa_d[15:8] = wbs_sel_i[1] ? wbs_dat_i[15:8] : opa_q[15:8];
            end else begin
                opb_d[7:0]  = wbs_sel_i[0] ? wbs_dat_i[7:0]  : opb_q[7:0];
                opb_d[15:8] = wbs_sel_i[1] ? wbs_dat_i[15:8] : opb_q[15:8];
            end
        end else begin
            overrun_d = overrun_d;
        end

        if (wr_s && off_s == 3'd2) begin
`ifdef KSA_FE_IRQ_EN
            irq_en_d = wbs_dat_i[2];
`endif
            if (wbs_dat_i[1]) begin
                done_d    = 1'b0;
                overrun_d = 1'b0;
            end else begin
                done_d = done_d;
            end
            if (wbs_dat_i[0] && busy_s) begin
                overrun_d = 1'b1;
            end else if (wbs_dat_i[0]) begin
                state_d = ST_SETTLE;
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                done_d  = 1'b0;
            end else begin
                state_d = state_d;
            end
        end else begin
            state_d = state_d;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_d;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                result_d = {ksa_cout, ksa_sum};
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers, cleared by the asynchronous reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            opa_q     <= 16'd0;
            opb_q     <= 16'd0;
            result_q  <= 17'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
`ifdef KSA_FE_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
`ifdef KSA_FE_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign ksa_a     = opa_q;
    assign ksa_b     = opb_q;
`ifdef KSA_FE_IRQ_EN
    assign irq_o     = irq_q;
`else
    assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ksa16_wb_frontend.sv
// Self-checking bench for ksa16_wb_frontend: cycle-level register model plus directed literal checks.
module tb_ksa16_wb_frontend;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          S    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;
    logic [15:0] ksa_a, ksa_b, ksa_sum;
    logic        ksa_cout, irq;

    int errors = 0;
    int checks = 0;

    // Model state
    int          cycle = 0;
    int          start_edge = -100;
    logic [15:0] m_opa = 16'd0, m_opb = 16'd0;
    logic [16:0] m_result = 17'd0, m_pend = 17'd0;
    logic        m_done = 1'b0, m_ovr = 1'b0, m_irq_en = 1'b0, m_irq = 1'b0;
    logic        m_ack = 1'b0;
    logic [31:0] m_dat = 32'd0;

    always #5 clk = ~clk;

    assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b};

    ksa16_wb_frontend #(.BASE_ADDR(BASE), .SETTLE_CYCLES(S)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .ksa_a(ksa_a), .ksa_b(ksa_b), .ksa_sum(ksa_sum), .ksa_cout(ksa_cout),
        .irq_o(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return (cycle >= start_edge) && (cycle <= start_edge + S);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return {16'd0, m_opa};
            3'd1: return {16'd0, m_opb};
`ifdef KSA_FE_IRQ_EN
            3'd2: return {29'd0, m_irq_en, 2'b00};
`endif
            3'd3: return {29'd0, m_ovr, m_done, m_busy()};
            3'd4: return {15'd0, m_result};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [31:0] d, input logic [3:0] s);
        return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
    endfunction

    // Apply a write to the model at the acking edge; pb is busy as seen before that edge.
    task automatic m_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s, input logic pb);
        if (off == 3'd0) begin
            if (pb) m_ovr = 1'b1; else m_opa = merge(m_opa, d, s);
        end else if (off == 3'd1) begin
            if (pb) m_ovr = 1'b1; else m_opb = merge(m_opb, d, s);
        end else if (off == 3'd2) begin
`ifdef KSA_FE_IRQ_EN
            m_irq_en = d[2];
`endif
            if (d[1]) begin m_done = 1'b0; m_ovr = 1'b0; end
            if (d[0]) begin
                if (pb) m_ovr = 1'b1;
                else begin
                    start_edge = cycle;
                    m_done = 1'b0;
                    m_pend = {1'b0, m_opa} + {1'b0, m_opb};
                end
            end
        end
    endtask

    // One clock edge: advance model time, interrupt flop and the pending capture.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        m_irq = m_done & m_irq_en;
        m_ack = 1'b0;
        m_dat = 32'd0;
        if (cycle == start_edge + S + 1) begin
            m_done = 1'b1;
            m_result = m_pend;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        logic        hit, pb;
        logic [31:0] exp;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        hit = (a[31:5] == BASE[31:5]);
        pb  = m_busy();
        exp = (hit && !w) ? m_read(a[4:2]) : 32'd0;
        tick();
        m_ack = hit;
        m_dat = exp;
        if (hit && w) m_write(a[4:2], d, s, pb);
        rd = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d);
        logic [31:0] rd;
        wb_acc(1'b1, BASE + {27'd0, off}, d, 4'hF, rd);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        wb_acc(1'b0, BASE + {27'd0, off}, 32'd0, 4'hF, rd);
        check(name, rd, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start_edge = -100;
        m_opa = 16'd0; m_opb = 16'd0; m_result = 17'd0;
        m_done = 1'b0; m_ovr = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
        m_ack = 1'b0; m_dat = 32'd0;
        #2;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_a", {16'd0, ksa_a}, 32'd0);
        check("rst_b", {16'd0, ksa_b}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ack", {31'd0, ack}, {31'd0, m_ack});
            check("dat", rdat, m_dat);
            check("ksa_a", {16'd0, ksa_a}, {16'd0, m_opa});
            check("ksa_b", {16'd0, ksa_b}, {16'd0, m_opb});
            check("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [31:0] rd;
        do_reset();
        rd_chk("reset_result", 5'h10, 32'h0000_0000);

        // Basic add
        wr(5'h00, 32'h0000_1234);
        wr(5'h04, 32'h0000_4321);
        wr(5'h08, 32'h0000_0001);
        rd_chk("busy_status", 5'h0C, 32'h0000_0001);
        idle(1);
        rd_chk("done_status", 5'h0C, 32'h0000_0002);
        rd_chk("basic_result", 5'h10, 32'h0000_5555);

        // Carry out, then clear
        wr(5'h00, 32'h0000_FFFF);
        wr(5'h04, 32'h0000_0001);
        wr(5'h08, 32'h0000_0001);
        idle(2);
        rd_chk("carry_result", 5'h10, 32'h0001_0000);
        wr(5'h08, 32'h0000_0002);
        rd_chk("clr_status", 5'h0C, 32'h0000_0000);
        rd_chk("ctrl_reads0", 5'h08, 32'h0000_0000);

        // Byte select
        wr(5'h00, 32'h0000_AAAA);
        wb_acc(1'b1, BASE, 32'h0000_0055, 4'b0001, rd);
        rd_chk("bytesel_opa", 5'h00, 32'h0000_AA55);

        // Overrun: OPB write during settle is dropped
        wr(5'h08, 32'h0000_0001);
        wr(5'h04, 32'h0000_7777);
        rd_chk("ovr_opb", 5'h04, 32'h0000_0001);
        idle(1);
        rd_chk("ovr_status", 5'h0C, 32'h0000_0006);
        rd_chk("ovr_result", 5'h10, 32'h0000_AA56);

        // CLR_DONE and START together
        wr(5'h08, 32'h0000_0003);
        idle(2);
        rd_chk("clrstart_status", 5'h0C, 32'h0000_0002);

        // Held strobe: one ack every two cycles
        acks = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h0C; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            logic taken;
            logic [31:0] exp;
            taken = !m_ack;
            exp = m_read(3'd3);
            tick();
            if (taken) begin m_ack = 1'b1; m_dat = exp; end
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        tick();
        check("held_acks", acks, 32'd2);

        // Unmapped offset and out-of-window access
        rd_chk("unmapped_rd", 5'h14, 32'h0000_0000);
        wb_acc(1'b1, BASE + 32'h20, 32'h0000_1111, 4'hF, rd);
        wb_acc(1'b1, 32'h4000_0000, 32'h0000_2222, 4'hF, rd);
        rd_chk("outwin_opa", 5'h00, 32'h0000_AA55);

        // Reset during settle aborts the capture
        wr(5'h00, 32'h0000_0001);
        wr(5'h04, 32'h0000_0001);
        wr(5'h08, 32'h0000_0001);
        do_reset();
        idle(3);
        rd_chk("abort_result", 5'h10, 32'h0000_0000);
        rd_chk("abort_status", 5'h0C, 32'h0000_0000);

`ifdef KSA_FE_IRQ_EN
        wr(5'h08, 32'h0000_0004);
        rd_chk("irqen_rd", 5'h08, 32'h0000_0004);
        wr(5'h00, 32'h0000_8000);
        wr(5'h04, 32'h0000_8000);
        wr(5'h08, 32'h0000_0005);
        idle(3);
        check("irq_set", {31'd0, irq}, 32'd1);
        rd_chk("irq_result", 5'h10, 32'h0001_0000);
        wr(5'h08, 32'h0000_0006);
        idle(1);
        check("irq_clr", {31'd0, irq}, 32'd0);
`endif
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
